arb8_rr: RTL and testbench

Round-robin arbiter sharing one resource among eight requesters. It uses an `Or8Way` reduction of the request vector as its "any request" detector. The arbiter holds a registered one-hot grant for as long as the owner keeps its request asserted, up to an optional hold limit. It then hands the grant directly to the next requester in rotating priority order. It sits between the eight request lines and the shared datapath, which is enabled by `gnt`/`gnt_id`.

---
 rtl/arb8_rr_pkg.sv | 22 ++
 rtl/arb8_rr_if.sv | 13 +
 rtl/arb8_rr_or8way.sv | 9 +
 rtl/arb8_rr_pick.sv | 33 +++
 rtl/arb8_rr.sv | 101 ++++++++++
 tb/tb_arb8_rr.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/arb8_rr_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: state encoding,
// requester count, index width and a one-hot helper.
`ifndef ARB8_RR_PKG_SV
`define ARB8_RR_PKG_SV

package arb8_rr_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

`endif

// File: rtl/arb8_rr_if.sv
// Request/grant bundle between the eight requesters and the arbiter.
interface arb8_rr_if;
  import arb8_rr_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             busy;
  logic             revoked;

  modport master (output req, input gnt, input gnt_id, input busy, input revoked);
  modport slave  (input req, output gnt, output gnt_id, output busy, output revoked);
endinterface

// File: rtl/arb8_rr_or8way.sv
// Eight-input OR reduction used as the "any request pending" detector.
module Or8Way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/arb8_rr_pick.sv
// Rotating-priority selector: rotate the request vector so that index ptr
// lands at bit 0, take the lowest set bit, then add ptr back (mod 8).
module rr_pick8
  import arb8_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] first;

  // rot[i] is the request of the requester i places after ptr in scan order
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  // lowest set bit of the rotated vector wins; the 3-bit add wraps 7->0
  always_comb begin
    first = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = IDX_W'(i);
    end
    valid = |rot;
    idx   = first + ptr;
  end

endmodule

// File: rtl/arb8_rr.sv
// Round-robin arbiter for eight requesters. The owner keeps a registered
// one-hot grant while it holds its request, optionally limited to MAX_HOLD
// consecutive cycles, after which the grant moves to the next requester in
// rotating order with no idle cycle in between.
module arb8_rr
  import arb8_rr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic       clk,
  input logic       rst_n,
  arb8_rr_if.slave  bus
);

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             revoked;

  logic             any_req;
  logic             owner_req;
  logic             drop;
  logic             expire;
  logic [IDX_W-1:0] scan_ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  Or8Way u_any (
    .in  (bus.req),
    .out (any_req)
  );

  // A drop wins over an expiry in the same cycle, so expire requires the
  // owner to still be requesting. On either, the scan starts just past the
  // owner, which leaves the owner itself as lowest priority.
  assign owner_req = bus.req[gnt_id];
  assign drop      = (state == ST_OWNED) && !owner_req;
  assign expire    = (state == ST_OWNED) && owner_req && (MAX_HOLD != 0) &&
                     (hold_cnt == HOLD_LAST);
  assign scan_ptr  = (drop || expire) ? gnt_id + 3'd1 : ptr;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (scan_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Arbitration state machine with registered grant, owner index and revoke pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      revoked  <= 1'b0;
    end else begin
      revoked <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_OWNED;
            gnt      <= onehot8(pick_idx);
            gnt_id   <= pick_idx;
            hold_cnt <= '0;
          end
        end
        ST_OWNED: begin
          if (drop || expire) begin
            ptr     <= scan_ptr;
            revoked <= expire;
            if (pick_valid) begin
              gnt      <= onehot8(pick_idx);
              gnt_id   <= pick_idx;
              hold_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              gnt      <= '0;
              gnt_id   <= '0;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.gnt_id  = gnt_id;
  assign bus.busy    = (state == ST_OWNED);
  assign bus.revoked = revoked;

endmodule

// File: tb/tb_arb8_rr.sv
// Testbench for arb8_rr: two instances (MAX_HOLD=4 and MAX_HOLD=0) share one
// request vector and are compared every cycle against an owner/pointer model,
// plus directed spot checks on the key scenarios.
module tb_arb8_rr;

  logic clk;
  logic rst_n;
  logic [7:0] req;

  int checks = 0;
  int errors = 0;

  // model state, index 0 = MAX_HOLD 4, index 1 = MAX_HOLD 0
  int mOwner[2];
  int mPtr[2];
  int mHeld[2];
  bit mRev[2];
  int mMax[2] = '{4, 0};

  arb8_rr_if bus4 ();
  arb8_rr_if bus0 ();

  assign bus4.req = req;
  assign bus0.req = req;

  arb8_rr #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  arb8_rr #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int scanFrom(input int start, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [7:0] r, input logic rn);
    for (int m = 0; m < 2; m++) begin
      mRev[m] = 1'b0;
      if (!rn) begin
        mOwner[m] = -1;
        mPtr[m]   = 0;
        mHeld[m]  = 0;
      end else if (mOwner[m] < 0) begin
        mOwner[m] = scanFrom(mPtr[m], r);
        mHeld[m]  = 1;
      end else if (!r[mOwner[m]]) begin
        mPtr[m]   = (mOwner[m] + 1) % 8;
        mOwner[m] = scanFrom(mPtr[m], r);
        mHeld[m]  = 1;
      end else if (mMax[m] != 0 && mHeld[m] == mMax[m]) begin
        mPtr[m]   = (mOwner[m] + 1) % 8;
        mOwner[m] = scanFrom(mPtr[m], r);
        mHeld[m]  = 1;
        mRev[m]   = 1'b1;
      end else begin
        mHeld[m]  = mHeld[m] + 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compareDut(input int m, input string nm, input logic [7:0] g,
                            input logic [2:0] id, input logic b, input logic rv);
    int expG;
    expG = (mOwner[m] < 0) ? 0 : (1 << mOwner[m]);
    checkOutput({nm, ".gnt"}, int'(g), expG);
    checkOutput({nm, ".busy"}, int'(b), (mOwner[m] < 0) ? 0 : 1);
    checkOutput({nm, ".revoked"}, int'(rv), int'(mRev[m]));
    if (mOwner[m] >= 0) checkOutput({nm, ".gnt_id"}, int'(id), mOwner[m]);
  endtask

  // drive inputs, let one edge sample them, then compare both instances
  task automatic applyStimulus(input logic [7:0] r, input logic rn);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    modelStep(r, rn);
    #1;
    compareDut(0, "h4", bus4.gnt, bus4.gnt_id, bus4.busy, bus4.revoked);
    compareDut(1, "h0", bus0.gnt, bus0.gnt_id, bus0.busy, bus0.revoked);
  endtask

  initial begin
    logic [7:0] r;
    logic       rn;
    req   = 8'h00;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mOwner[m] = -1; mPtr[m] = 0; mHeld[m] = 0; mRev[m] = 1'b0;
    end

    // reset state
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("reset.gnt", int'(bus4.gnt), 0);
    checkOutput("reset.gnt_id", int'(bus4.gnt_id), 0);
    checkOutput("reset.busy", int'(bus4.busy), 0);
    checkOutput("reset.revoked", int'(bus4.revoked), 0);
    applyStimulus(8'h00, 1'b1);

    // single requester
    applyStimulus(8'h04, 1'b1);
    checkOutput("single.gnt", int'(bus0.gnt), 8'h04);
    checkOutput("single.gnt_id", int'(bus0.gnt_id), 2);
    applyStimulus(8'h04, 1'b1);
    checkOutput("single.busy", int'(bus0.busy), 1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("single.drop", int'(bus0.gnt), 0);

    // rotation: all requesting, each owner drops right after its grant
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("rot.first", int'(bus0.gnt_id), 0);
    for (int i = 0; i < 8; i++) begin
      r = 8'hFF & ~bus0.gnt;
      applyStimulus(r, 1'b1);
      checkOutput("rot.next", int'(bus0.gnt_id), (i + 1) % 8);
      checkOutput("rot.busy", int'(bus0.busy), 1);
    end

    // wrap: leave ptr at 6, then 0 beats 5
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h21, 1'b1);
    checkOutput("wrap.gnt", int'(bus0.gnt), 8'h01);
    applyStimulus(8'h20, 1'b1);
    checkOutput("wrap.hand", int'(bus0.gnt), 8'h20);

    // forced release on the MAX_HOLD=4 instance
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(8'h03, 1'b1);
    checkOutput("force.hold", int'(bus4.gnt), 8'h01);
    applyStimulus(8'h03, 1'b1);
    checkOutput("force.gnt", int'(bus4.gnt), 8'h02);
    checkOutput("force.rev", int'(bus4.revoked), 1);
    checkOutput("force.nolimit", int'(bus0.gnt), 8'h01);
    for (int i = 0; i < 8; i++) applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h00, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(8'h01, 1'b1);
    checkOutput("force.solo", int'(bus4.gnt), 8'h01);

    // reset during ownership
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h20, 1'b1);
    checkOutput("midrst.own", int'(bus4.gnt_id), 5);
    applyStimulus(8'h20, 1'b0);
    checkOutput("midrst.gnt", int'(bus4.gnt), 0);
    checkOutput("midrst.busy", int'(bus4.busy), 0);
    applyStimulus(8'h21, 1'b1);
    checkOutput("midrst.restart", int'(bus4.gnt), 8'h01);

    // owner drops in its last allowed cycle: normal hand-off
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h02, 1'b1);
    checkOutput("simul.gnt", int'(bus4.gnt), 8'h02);
    checkOutput("simul.rev", int'(bus4.revoked), 0);

    // randomized traffic against the model
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
      rn = ($urandom_range(49) != 0);
      applyStimulus(r, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
